// File: rtl/gan_pkg.sv
// Shared definitions for the GAN datapath blocks: defaults, activation codes,
// the dense-layer state encoding and a width helper.
package gan_pkg;
  localparam int FRAC_DEF = 16;
  localparam int ACT_NONE = 0;
  localparam int ACT_RELU = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_BIAS, ST_DONE} state_t;

  // Minimum of one bit, so single-entry counters and selects stay legal.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mac_acc.sv
// Signed multiply-accumulate with a synchronous clear. The full-width product
// is accumulated with enough headroom for N_IN terms.
module mac_acc
  import gan_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 2,
  localparam int AW    = 2*WIDTH + cw(N_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [AW-1:0]    acc
);
  logic signed [2*WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (!rst)     acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  end
endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed dense layer: one MAC walks N_OUT neurons of N_IN products,
// then a bias/shift/saturate/activation stage writes each y[j].
module dense_layer_seq
  import gan_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int FRAC   = FRAC_DEF,
  parameter  int N_IN   = 2,
  parameter  int N_OUT  = 9,
  parameter  int N_BANK = 2,
  parameter  int ACT    = ACT_RELU,
  localparam int BW     = cw(N_BANK),
  localparam int WA     = cw(N_BANK*N_IN*N_OUT),
  localparam int BA     = cw(N_BANK*N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*WIDTH-1:0]   in_vec,
  input  logic [BW-1:0]           in_bank,
  output logic [WA-1:0]           w_addr,
  input  logic [WIDTH-1:0]        w_data,
  output logic [BA-1:0]           b_addr,
  input  logic [WIDTH-1:0]        b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*WIDTH-1:0]  out_data,
  output logic                    busy
);
  localparam int IW = cw(N_IN);
  localparam int JW = cw(N_OUT);
  localparam int AW = 2*WIDTH + cw(N_IN);
  localparam int SW = AW + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t                          state, nxt;
  logic [N_IN-1:0][WIDTH-1:0]      x_q;
  logic [BW-1:0]                   bank_q;
  logic [IW-1:0]                   i_q;
  logic [JW-1:0]                   j_q;
  logic [N_OUT-1:0][WIDTH-1:0]     y_q;
  logic                            accept, last_i, last_j, acc_clr, mac_en, y_we;
  logic signed [WIDTH-1:0]         x_cur;
  logic signed [AW-1:0]            acc;
  logic signed [SW-1:0]            bias_ext, sum, shr;
  logic [WIDTH-1:0]                y_sat, y_val;

  assign accept = in_valid & in_ready;
  assign last_i = (32'(i_q) == N_IN - 1);
  assign last_j = (32'(j_q) == N_OUT - 1);
  assign x_cur  = x_q[i_q];

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (accept)    nxt = ST_MAC;
      ST_MAC:  if (last_i)    nxt = ST_BIAS;
      ST_BIAS: nxt = last_j ? ST_DONE : ST_MAC;
      ST_DONE: if (out_ready) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_MAC) || (state == ST_BIAS);
    mac_en    = (state == ST_MAC);
    y_we      = (state == ST_BIAS);
    acc_clr   = accept || (state == ST_BIAS);
  end

  mac_acc #(.WIDTH(WIDTH), .N_IN(N_IN)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (mac_en),
    .a   (x_cur),
    .b   (w_data),
    .acc (acc)
  );

  // Bias is aligned to the product's 2*FRAC scale before the single rescale shift.
  always_comb begin
    bias_ext = {{(SW-WIDTH){b_data[WIDTH-1]}}, b_data} <<< FRAC;
    sum      = {acc[AW-1], acc} + bias_ext;
    shr      = sum >>> FRAC;
    if (shr > MAXV)      y_sat = MAXV[WIDTH-1:0];
    else if (shr < MINV) y_sat = MINV[WIDTH-1:0];
    else                 y_sat = shr[WIDTH-1:0];
    y_val = (ACT == ACT_RELU && y_sat[WIDTH-1]) ? '0 : y_sat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q    <= '0;
      bank_q <= '0;
      i_q    <= '0;
      j_q    <= '0;
      y_q    <= '0;
    end else begin
      if (accept) begin
        x_q    <= in_vec;
        bank_q <= in_bank;
        i_q    <= '0;
        j_q    <= '0;
      end
      if (mac_en && !last_i) i_q <= i_q + 1'b1;
      // j returns to 0 after the last neuron so idle addresses sit at the bank base.
      if (y_we) begin
        y_q[j_q] <= y_val;
        i_q      <= '0;
        j_q      <= last_j ? '0 : j_q + 1'b1;
      end
    end
  end

  assign w_addr   = WA'(32'(bank_q) * (N_IN*N_OUT) + 32'(j_q) * N_IN + 32'(i_q));
  assign b_addr   = BA'(32'(bank_q) * N_OUT + 32'(j_q));
  assign out_data = y_q;
endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: a ReLU and an identity instance run in lockstep
// against an arithmetic reference model of the layer.
module tb_dense_layer_seq;
  localparam int W = 32, NI = 2, NO = 9, NB = 2;
  localparam int OW = NO*W;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [NI*W-1:0] in_vec = '0;
  logic [0:0] in_bank = '0;

  logic in_ready_r, out_valid_r, busy_r, in_ready_l, out_valid_l, busy_l;
  logic [5:0] w_addr_r, w_addr_l;
  logic [4:0] b_addr_r, b_addr_l;
  logic [W-1:0] w_data_r, b_data_r, w_data_l, b_data_l;
  logic [OW-1:0] out_data_r, out_data_l;

  logic [W-1:0] wmem [NB*NI*NO];
  logic [W-1:0] bmem [NB*NO];
  assign w_data_r = wmem[w_addr_r];
  assign b_data_r = bmem[b_addr_r];
  assign w_data_l = wmem[w_addr_l];
  assign b_data_l = bmem[b_addr_l];

  dense_layer_seq #(.ACT(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .in_vec(in_vec),
    .in_bank(in_bank), .w_addr(w_addr_r), .w_data(w_data_r), .b_addr(b_addr_r),
    .b_data(b_data_r), .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .busy(busy_r));

  dense_layer_seq #(.ACT(0)) u_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_vec(in_vec),
    .in_bank(in_bank), .w_addr(w_addr_l), .w_data(w_data_l), .b_addr(b_addr_l),
    .b_data(b_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .busy(busy_l));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // y = act(sat(floor((sum x*w + b*2^16) / 2^16)))
  function automatic logic [W-1:0] ref_y(input int j, input int bank,
                                         input logic [NI*W-1:0] v, input int act);
    logic signed [95:0] s;
    logic signed [W-1:0] xi, wi, bj;
    s = '0;
    for (int i = 0; i < NI; i++) begin
      xi = v[i*W +: W];
      wi = wmem[bank*NI*NO + j*NI + i];
      s += 96'(xi) * 96'(wi);
    end
    bj = bmem[bank*NO + j];
    s += 96'(bj) * 96'sd65536;
    s = s >>> 16;
    if (s > 96'sd2147483647)       s = 96'sd2147483647;
    else if (s < -96'sd2147483648) s = -96'sd2147483648;
    if (act == 1 && s < 0) s = '0;
    return s[W-1:0];
  endfunction

  task automatic fill(input int bank, input logic [W-1:0] wv, input logic [W-1:0] bv);
    for (int k = 0; k < NI*NO; k++) wmem[bank*NI*NO + k] = wv;
    for (int k = 0; k < NO; k++)    bmem[bank*NO + k] = bv;
  endtask

  task automatic run(input logic [W-1:0] x0, input logic [W-1:0] x1, input int bank,
                     input int hold, input string tag);
    int cyc;
    logic [NI*W-1:0] v;
    logic [OW-1:0] exp_r, exp_l;
    v = {x1, x0};
    for (int j = 0; j < NO; j++) begin
      exp_r[j*W +: W] = ref_y(j, bank, v, 1);
      exp_l[j*W +: W] = ref_y(j, bank, v, 0);
    end
    cyc = 0;
    while (!in_ready_r && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk({tag, " ready"}, in_ready_r, 1'b1);
    in_vec = v; in_bank = 1'(bank); in_valid = 1'b1;
    @(posedge clk); #1;
    // garbage on the inputs while busy must not disturb the captured copy
    in_vec = {$urandom, $urandom}; in_bank = ~in_bank;
    chk({tag, " w_addr0"}, w_addr_r, 6'(bank*NI*NO));
    chk({tag, " busy"}, {busy_r, busy_l, in_ready_r}, 3'b110);
    cyc = 0;
    while (!out_valid_r && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      in_valid = (cyc < 20);
      if (cyc == 2) chk({tag, " b_addr0"}, b_addr_r, 5'(bank*NO));
    end
    in_valid = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'd27);
    chk({tag, " vld_l"}, out_valid_l, 1'b1);
    for (int j = 0; j < NO; j++) begin
      chk($sformatf("%s y_relu[%0d]", tag, j), out_data_r[j*W +: W], exp_r[j*W +: W]);
      chk($sformatf("%s y_lin[%0d]", tag, j), out_data_l[j*W +: W], exp_l[j*W +: W]);
    end
    chk({tag, " done flags"}, {busy_r, in_ready_r}, 2'b00);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold flags"}, {out_valid_r, out_valid_l, in_ready_r, in_ready_l}, 4'b1100);
      chk({tag, " hold data_r"}, out_data_r, exp_r);
      chk({tag, " hold data_l"}, out_data_l, exp_l);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post hs"}, {out_valid_r, in_ready_r, in_ready_l}, 3'b011);
    chk({tag, " retained"}, out_data_l, exp_l);
  endtask

  initial begin
    logic [OW-1:0] zero;
    zero = '0;
    for (int k = 0; k < NB*NI*NO; k++) wmem[k] = '0;
    for (int k = 0; k < NB*NO; k++)    bmem[k] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset flags", {in_ready_r, out_valid_r, busy_r, in_ready_l, out_valid_l, busy_l}, 6'b100100);
    chk("reset data", out_data_r | out_data_l, zero);

    fill(0, 32'h0001_0000, 32'h0000_8000);
    run(32'h0002_0000, 32'h0003_0000, 0, 0, "basic");
    chk("basic y0", out_data_r[W-1:0], 32'h0005_8000);

    fill(0, 32'h0001_0000, 32'h0);
    run(32'hFFFE_0000, 32'hFFFD_0000, 0, 0, "relu");
    chk("relu y0", out_data_r[W-1:0], 32'h0);
    chk("lin y0", out_data_l[W-1:0], 32'hFFFB_0000);

    fill(0, 32'h0002_0000, 32'h0);
    run(32'h7FFF_0000, 32'h7FFF_0000, 0, 0, "sat+");
    chk("sat+ y8", out_data_r[8*W +: W], 32'h7FFF_FFFF);
    fill(0, 32'hFFFE_0000, 32'h0);
    run(32'h7FFF_0000, 32'h7FFF_0000, 0, 0, "sat-");
    chk("sat- y8", out_data_l[8*W +: W], 32'h8000_0000);

    fill(0, 32'h0001_0000, 32'h0);
    fill(1, 32'h0002_0000, 32'h0);
    run(32'h0001_0000, 32'h0001_0000, 0, 0, "bank0");
    chk("bank0 y0", out_data_l[W-1:0], 32'h0002_0000);
    run(32'h0001_0000, 32'h0001_0000, 1, 0, "bank1");
    chk("bank1 y0", out_data_l[W-1:0], 32'h0004_0000);

    fill(1, 32'h0000_C000, 32'hFFFF_4000);
    run(32'h0003_8000, 32'hFFFE_2000, 1, 10, "bkpr");

    // reset ten cycles into a transaction
    in_vec = {32'h0005_0000, 32'h0004_0000}; in_bank = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst flags", {out_valid_r, in_ready_r, busy_r, out_valid_l, in_ready_l}, 5'b01001);
    chk("midrst data", out_data_r | out_data_l, zero);
    run(32'h0004_0000, 32'h0005_0000, 0, 0, "afterrst");

    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < NB*NI*NO; k++) wmem[k] = (t < 10) ? 32'($signed(16'($urandom))) <<< 4 : $urandom;
      for (int k = 0; k < NB*NO; k++)    bmem[k] = $urandom;
      run($urandom, $urandom, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
